// File: rtl/bin2bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg
// Shared types and defaults for the sequential binary-to-BCD converter.
//   bcd_digit_t   : one packed BCD digit (drives one seven-segment decoder)
//   b2b_state_t   : converter FSM states (IDLE, SHIFT)
//   B2B_W_DEFAULT : default binary input width
//   B2B_N_DEFAULT : default number of BCD digits
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } b2b_state_t;

  localparam int B2B_W_DEFAULT = 14;
  localparam int B2B_N_DEFAULT = 4;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// Combinational digit correction for shift-and-add-3: a digit of 5 or more
// gets +3 so that the following left shift carries correctly into the next
// decimal digit.
//   d : digit before correction
//   y : corrected digit (d+3 when d >= 5, otherwise d)
// ---------------------------------------------------------------------------
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] y
);

  // Add 3 to digits of 5 and above; 4-bit wrap never occurs for valid digits.
  always_comb begin
    y = d;
    if (d >= 4'd5) begin
      y = d + 4'd3;
    end else begin
      y = d;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter, one input bit per cycle
// (shift-and-add-3). The result is held between conversions so downstream
// seven-segment displays never flicker.
//
// Parameters:
//   W : binary input width (2..32)
//   N : number of BCD digits (1..8)
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : conversion request, sampled only while idle
//   bin   : unsigned input value, captured on the accepting edge
//   busy  : conversion in progress (W cycles)
//   done  : one-cycle pulse, bcd/ovf valid from this cycle on
//   bcd   : packed digits, digit 0 (units) in bits [3:0]
//   ovf   : last converted value was >= 10^N
//
// Build option:
//   BIN2BCD_SAT_EN : when defined, an overflowing value yields all-9s on bcd;
//                    when undefined, bcd holds the value mod 10^N.
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W = B2B_W_DEFAULT,
  parameter int N = B2B_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*N-1:0] bcd,
  output logic           ovf
);

  localparam int CW = $clog2(W + 1);
  localparam int SW = 4 * N + W;

  b2b_state_t      state_r;
  b2b_state_t      state_nx_s;
  logic [CW-1:0]   cnt_r;
  logic [SW-1:0]   sr_r;
  logic            sticky_r;
  logic            busy_r;
  logic            done_r;
  logic [4*N-1:0]  bcd_r;
  logic            ovf_r;

  logic [4*N-1:0]  adj_s;
  logic [SW-1:0]   shift_s;
  logic            ovf_fin_s;
  logic            last_s;
  logic [4*N-1:0]  res_bcd_s;

  // Per-digit add-3 correction on the digit field of the shift register.
  for (genvar i = 0; i < N; i++) begin : g_digit
    bcd_add3 u_add3 (
      .d (sr_r[W + 4*i +: 4]),
      .y (adj_s[4*i +: 4])
    );
  end

  // The bit leaving the top digit is a multiple of 10^N; dropping it leaves
  // the value mod 10^N, while remembering it flags the overflow.
  assign shift_s   = {adj_s[4*N-2:0], sr_r[W-1:0], 1'b0};
  assign ovf_fin_s = sticky_r | adj_s[4*N-1];
  assign last_s    = (cnt_r == CW'(1));

  // Result selection for the completing edge (saturating or modulo).
  always_comb begin
    res_bcd_s = shift_s[SW-1:W];
`ifdef BIN2BCD_SAT_EN
    if (ovf_fin_s) begin
      res_bcd_s = {N{4'h9}};
    end else begin
      res_bcd_s = shift_s[SW-1:W];
    end
`else
    res_bcd_s = shift_s[SW-1:W];
`endif
  end

  // Next-state logic: accept a request while idle, stop after the W-th shift.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = SHIFT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = SHIFT;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= '0;
      sr_r     <= '0;
      sticky_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      bcd_r    <= '0;
      ovf_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            sr_r     <= {{(4*N){1'b0}}, bin};
            cnt_r    <= CW'(W);
            sticky_r <= 1'b0;
            busy_r   <= 1'b1;
          end
        end
        SHIFT: begin
          sr_r     <= shift_s;
          cnt_r    <= cnt_r - CW'(1);
          sticky_r <= ovf_fin_s;
          if (last_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            bcd_r  <= res_bcd_s;
            ovf_r  <= ovf_fin_s;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign bcd  = bcd_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
// Directed scoreboard bench for bin2bcd_seq at the default W=14, N=4.
// Stimulus pushes the expected {bcd, ovf, done edge} per accepted request;
// a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  localparam int W = B2B_W_DEFAULT;
  localparam int N = B2B_N_DEFAULT;

`ifdef BIN2BCD_SAT_EN
  localparam logic [15:0] EXP_BIG_BCD = 16'h9999;
`else
  localparam logic [15:0] EXP_BIG_BCD = 16'h2345;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   bin;
  logic           busy;
  logic           done;
  logic [4*N-1:0] bcd;
  logic           ovf;

  typedef struct {
    logic [4*N-1:0] bcd;
    logic           ovf;
    int             edge_n;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   edge_cnt = 0;
  int   busy_len = 0;

  bin2bcd_seq #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic push_exp(input logic [15:0] b, input logic o, input int e);
    exp_t x;
    x.bcd    = b;
    x.ovf    = o;
    x.edge_n = e;
    sb.push_back(x);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at edge %0d, expected no done", edge_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bcd", 32'(bcd), 32'(e.bcd));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("done_edge", 32'(edge_cnt), 32'(e.edge_n));
        check("busy_in_done", 32'(busy), 32'(0));
      end
    end
  end

  // Busy run-length monitor: each completed conversion is busy for W cycles.
  always @(negedge clk) begin
    if (rst) begin
      busy_len = 0;
    end else if (busy) begin
      busy_len++;
    end else begin
      if (busy_len != 0) check("busy_len", 32'(busy_len), 32'(W));
      busy_len = 0;
    end
  end

  // One full conversion; bin is scrambled after the accepting edge.
  task automatic convert(input int value, input logic [15:0] eb, input logic eo);
    start = 1'b1;
    bin   = W'(value);
    @(posedge clk);
    #1;
    push_exp(eb, eo, edge_cnt + W);
    start = 1'b0;
    bin   = '1;
    repeat (W + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    #200000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_bcd",  32'(bcd),  32'(0));
    check("rst_ovf",  32'(ovf),  32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    convert(1234, 16'h1234, 1'b0);
    convert(0,    16'h0000, 1'b0);
    convert(9999, 16'h9999, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_bcd", 32'(bcd), 32'(16'h9999));
    end
    @(posedge clk);
    #1;
    convert(12345, EXP_BIG_BCD, 1'b1);

    // Second request during cycle 5 of a conversion must be ignored.
    start = 1'b1;
    bin   = W'(777);
    @(posedge clk);
    #1;
    k = edge_cnt;
    push_exp(16'h0777, 1'b0, k + W);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    bin   = W'(42);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (W + 5) @(posedge clk);
    #1;

    // start held high: back-to-back conversions every W+1 cycles.
    start = 1'b1;
    bin   = W'(8);
    @(posedge clk);
    #1;
    k = edge_cnt;
    push_exp(16'h0008, 1'b0, k + W);
    push_exp(16'h0008, 1'b0, k + W + (W + 1));
    push_exp(16'h0008, 1'b0, k + W + 2 * (W + 1));
    repeat (W + 2 * (W + 1)) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;

    // Reset in cycle 7 of a conversion discards it.
    start = 1'b1;
    bin   = W'(999);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_bcd",  32'(bcd),  32'(0));
    check("midrst_ovf",  32'(ovf),  32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    convert(56, 16'h0056, 1'b0);
    repeat (W + 3) @(posedge clk);
    #1;

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one input bit per cycle). It sits directly upstream of the per-digit seven-segment decoders. It converts an unsigned binary value into N packed BCD digits, and each 4-bit digit drives one decoder's `data` input. The interface is a start/busy/done handshake, and the result is held stable between conversions so the displays never flicker.

## Interface
- `W`, default 14: binary input width (2..32).
- `N`, default 4: number of BCD digits produced (1..8).
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request a conversion of `bin`; sampled only when idle.
- `bin` in W: unsigned value; captured on the accepting edge and free to change afterwards.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse; `bcd`/`ovf` valid from this cycle on.
- `bcd` out 4N: packed digits; digit 0 (units) in bits [3:0], digit N-1 most significant.
- `ovf` out 1: the last converted value was ≥ 10^N.

## Operation
- States: IDLE and SHIFT.
- IDLE with `start`=1 leads to SHIFT on the next edge:
  - the shift register is loaded with `bin` in its low W bits and zeros in its 4N digit bits;
  - the bit counter is set to W;
  - the overflow sticky bit is cleared.
- Each SHIFT cycle:
  - every digit ≥ 5 gets +3 (4-bit, no carry between digits);
  - the whole {digits, bin} register shifts left by 1;
  - the bit shifted out of digit N-1 is OR-ed into the overflow sticky bit;
  - the counter decrements.
- Leaving SHIFT: on the edge where the counter reaches its final shift, the state returns to IDLE, `bcd` and `ovf` are updated, and `done` is set.
- Truncation: discarding the bits shifted out of the top digit yields the value mod 10^N exactly.
- `start` while busy is ignored; no queueing.
- `start` high in the `done` cycle is accepted, because the state is IDLE.
- `bcd` and `ovf` change only on the edge that sets `done`, and hold otherwise.
- Reset at any time, including mid-conversion:
  - state IDLE, counter 0, shift register 0;
  - `busy`=0, `done`=0, `bcd`=0, `ovf`=0;
  - the in-flight conversion is discarded with no `done`.

## Timing
- `start` is sampled high in IDLE at edge k.
- `busy`=1 in cycles k+1 .. k+W, which is W cycles.
- `done`=1 only in cycle k+W+1; `busy`=0 in that cycle.
- Latency from accept to result is W+1 cycles; 15 at the defaults.
- Maximum throughput is one conversion per W+1 cycles, achieved by holding `start` high.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `BIN2BCD_SAT_EN`
  - Defined: when overflow occurs, `bcd` is forced to all-9s (0x9999 at N=4) and `ovf`=1.
  - Undefined: `bcd` holds the value mod 10^N and `ovf`=1 still flags the condition.
- No overflow: both builds produce identical results.

## Structure
- Package `bin2bcd_pkg`:
  - `bcd_digit_t` (logic [3:0]);
  - state enum `b2b_state_t` {IDLE, SHIFT};
  - constants `B2B_W_DEFAULT`=14 and `B2B_N_DEFAULT`=4.
- Sub-module `bcd_add3`:
  - combinational, one `bcd_digit_t` in and one out;
  - output = in+3 if in ≥ 5, else in;
  - instantiated N times in a generate loop.
- The counter is $clog2(W+1) bits wide.

## Test plan
- Reset, then `bin`=1234 with a one-cycle `start` → `busy` for 14 cycles, `done` in cycle 15, `bcd`=0x1234, `ovf`=0.
- `bin`=0 → `bcd`=0x0000 and `bin`=9999 → `bcd`=0x9999, both with `ovf`=0; `bcd` is held unchanged for 20 idle cycles after `done`.
- `bin`=12345:
  - with `BIN2BCD_SAT_EN` → `bcd`=0x9999, `ovf`=1;
  - without it → `bcd`=0x2345, `ovf`=1.
- `start` pulsed with `bin`=42 during cycle 5 of a conversion of 777 → the result is 0x0777, exactly one `done`, and the second request is ignored.
- `start` held high continuously with `bin`=8 → `done` every 15 cycles, each with `bcd`=0x0008.
- `rst` asserted in cycle 7 of a conversion → the next cycle shows `busy`=0, `bcd`=0, `ovf`=0, and no `done`; a new conversion of 56 then completes normally with `bcd`=0x0056.
